// File: rtl/piezo_seq_if.sv
// Bus bundle for the piezo tune sequencer: tune requests, note RAM write
// port and the drive/status outputs. The optional duty input exists only
// when PIEZO_SEQ_DUTY_EN is defined.
interface piezo_seq_if #(
    parameter int NUM_TUNES = 3,
    parameter int ROM_DEPTH = 16,
    parameter int PRD_W     = 15,
    parameter int DUR_W     = 26
);
    localparam int ADDR_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int TID_W  = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1;
    localparam int WORD_W = 1 + PRD_W + DUR_W;

    logic [NUM_TUNES-1:0]        req;
    logic [NUM_TUNES-1:0]        rpt_mask;
    logic [NUM_TUNES*ADDR_W-1:0] tune_start;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [WORD_W-1:0]           wr_data;
`ifdef PIEZO_SEQ_DUTY_EN
    logic [3:0]                  duty;
`endif
    logic                        piezo;
    logic                        piezo_n;
    logic                        busy;
    logic [TID_W-1:0]            tune_id;
    logic [ADDR_W-1:0]           note_idx;

    modport master (
        output req, rpt_mask, tune_start, wr_en, wr_addr, wr_data,
`ifdef PIEZO_SEQ_DUTY_EN
        output duty,
`endif
        input  piezo, piezo_n, busy, tune_id, note_idx
    );

    modport slave (
        input  req, rpt_mask, tune_start, wr_en, wr_addr, wr_data,
`ifdef PIEZO_SEQ_DUTY_EN
        input  duty,
`endif
        output piezo, piezo_n, busy, tune_id, note_idx
    );
endinterface

// File: rtl/piezo_seq.sv
// Piezo tune sequencer. Plays tunes from a writable note RAM
// (word = {last, prd, dur}), arbitrates the request lines by fixed priority
// (index 0 wins), gates masked tunes on the repeat pulse and only preempts
// at note boundaries. piezo/piezo_n are driven differentially while a
// pitched note plays and are both low otherwise.
// Optional feature macro: PIEZO_SEQ_DUTY_EN adds a 4-bit duty input
// (high time = duty/16 of the period); without it the duty is fixed at 50%.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | silent, waiting for an eligible request
// S_FETCH | one cycle: note word read from RAM and latched, counters cleared
// S_PLAY  | tone (or rest) running until the duration counter expires
module piezo_seq #(
    parameter int          FAST_SIM  = 1,
    parameter int          NUM_TUNES = 3,
    parameter int          ROM_DEPTH = 16,
    parameter int          PRD_W     = 15,
    parameter int          DUR_W     = 26,
    parameter logic [27:0] RPT_CNT   = 28'h8F0D180
) (
    input logic        clk,
    input logic        rst_n,
    piezo_seq_if.slave bus
);
    localparam int ADDR_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int TID_W  = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1;
    localparam int WORD_W = 1 + PRD_W + DUR_W;
    localparam int INC    = (FAST_SIM != 0) ? 64 : 1;

    localparam logic [27:0]       RPT_INC   = 28'(INC);
    localparam logic [PRD_W-1:0]  PRD_INC   = PRD_W'(INC);
    localparam logic [DUR_W-1:0]  DUR_INC   = DUR_W'(INC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [27:0]        rpt_cntr_q, rpt_cntr_d;
    logic [PRD_W-1:0]   prd_cntr_q, prd_cntr_d;
    logic [DUR_W-1:0]   dur_cntr_q, dur_cntr_d;
    logic [PRD_W-1:0]   cur_prd_q, cur_prd_d;
    logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;
    logic               cur_last_q, cur_last_d;
    logic [TID_W-1:0]   tune_id_q, tune_id_d;
    logic [ADDR_W-1:0]  note_idx_q, note_idx_d;

    logic                 rpt;
    logic [NUM_TUNES-1:0] elig;
    logic                 any_elig;
    logic [TID_W-1:0]     sel;
    logic [ADDR_W-1:0]    sel_start;
    logic                 note_end;
    logic                 tone_on;
    logic                 audible;

    logic [WORD_W-1:0] mem [ROM_DEPTH];
    logic [WORD_W-1:0] rd_word;

    // Note RAM write port; never reset so tunes survive a sequencer reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // FETCH latches this at the same edge a write may land, so a colliding
    // write is seen only by the next fetch (read-before-write)
    assign rd_word = mem[note_idx_q];

    // Free-running repeat counter; rpt is a one-cycle pulse at the interval
    always_comb begin
        rpt        = (rpt_cntr_q >= RPT_CNT);
        rpt_cntr_d = rpt ? '0 : rpt_cntr_q + RPT_INC;
    end

    // Eligibility and fixed-priority select (lowest index wins)
    always_comb begin
        elig     = bus.req & (~bus.rpt_mask | {NUM_TUNES{rpt}});
        any_elig = |elig;
        sel      = '0;
        for (int i = NUM_TUNES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = TID_W'(i);
            end
        end
        sel_start = bus.tune_start[int'(sel) * ADDR_W +: ADDR_W];
    end

    assign note_end = (dur_cntr_q >= cur_dur_q);

    // Next-state logic: arbitration, note fetch, counters and note advance
    always_comb begin
        state_d    = state_q;
        tune_id_d  = tune_id_q;
        note_idx_d = note_idx_q;
        prd_cntr_d = prd_cntr_q;
        dur_cntr_d = dur_cntr_q;
        cur_prd_d  = cur_prd_q;
        cur_dur_d  = cur_dur_q;
        cur_last_d = cur_last_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    tune_id_d  = sel;
                    note_idx_d = sel_start;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                {cur_last_d, cur_prd_d, cur_dur_d} = rd_word;
                prd_cntr_d = '0;
                dur_cntr_d = '0;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                dur_cntr_d = dur_cntr_q + DUR_INC;
                prd_cntr_d = (prd_cntr_q >= cur_prd_q) ? '0 : prd_cntr_q + PRD_INC;
                if (note_end) begin
                    if (any_elig && (sel < tune_id_q)) begin
                        tune_id_d  = sel;
                        note_idx_d = sel_start;
                        state_d    = S_FETCH;
                    end else if (cur_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // explicit wrap keeps non-power-of-two depths in range
                        note_idx_d = (note_idx_q == LAST_ADDR) ? '0 : note_idx_q + ADDR_ONE;
                        state_d    = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rpt_cntr_q <= '0;
            prd_cntr_q <= '0;
            dur_cntr_q <= '0;
            cur_prd_q  <= '0;
            cur_dur_q  <= '0;
            cur_last_q <= 1'b0;
            tune_id_q  <= '0;
            note_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rpt_cntr_q <= rpt_cntr_d;
            prd_cntr_q <= prd_cntr_d;
            dur_cntr_q <= dur_cntr_d;
            cur_prd_q  <= cur_prd_d;
            cur_dur_q  <= cur_dur_d;
            cur_last_q <= cur_last_d;
            tune_id_q  <= tune_id_d;
            note_idx_q <= note_idx_d;
        end
    end

`ifdef PIEZO_SEQ_DUTY_EN
    localparam int CMP_W = PRD_W + 4;
    logic [CMP_W-1:0] duty_lhs;
    logic [CMP_W-1:0] duty_rhs;

    // Tone shaping with programmable duty; duty=0 keeps both legs low
    always_comb begin
        duty_lhs = {prd_cntr_q, 4'b0000};
        duty_rhs = CMP_W'(cur_prd_q) * CMP_W'(bus.duty);
        tone_on  = (duty_lhs < duty_rhs);
        audible  = (state_q == S_PLAY) && (cur_prd_q != '0) && (bus.duty != 4'd0);
    end
`else
    // Tone shaping at a fixed 50% duty; rests (prd=0) keep both legs low
    always_comb begin
        tone_on = (prd_cntr_q < (cur_prd_q >> 1));
        audible = (state_q == S_PLAY) && (cur_prd_q != '0);
    end
`endif

    assign bus.piezo    = audible & tone_on;
    assign bus.piezo_n  = audible & ~tone_on;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.tune_id  = tune_id_q;
    assign bus.note_idx = note_idx_q;
endmodule

// File: tb/tb_piezo_seq.sv
// Bench for piezo_seq: every cycle the outputs are compared with a
// behavioural model (note position t, period phase t mod (prd+1), repeat
// pulse every RPT+1 cycles since reset), plus a priority table and
// hand-written timing sequences.
module tb_piezo_seq;
    localparam int NT  = 3;
    localparam int RD  = 16;
    localparam int AW  = 4;
    localparam int PW  = 15;
    localparam int DW  = 26;
    localparam int WW  = 1 + PW + DW;
    localparam int TW  = 2;
    localparam int RPT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piezo_seq_if #(.NUM_TUNES(NT), .ROM_DEPTH(RD), .PRD_W(PW), .DUR_W(DW)) bus ();

    piezo_seq #(
        .FAST_SIM(0), .NUM_TUNES(NT), .ROM_DEPTH(RD), .PRD_W(PW), .DUR_W(DW),
        .RPT_CNT(28'd2000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- reference model ----------------
    int m_since, m_tune, m_addr, m_prd, m_dur, m_t;
    bit m_fetch, m_play, m_last;
    logic [WW-1:0] ram_m [RD];

    function automatic int start_of(input int i);
        return int'(bus.tune_start[i*AW +: AW]);
    endfunction

    function automatic bit m_tone();
        int ph;
        ph = m_t % (m_prd + 1);
`ifdef PIEZO_SEQ_DUTY_EN
        return (ph * 16) < (m_prd * int'(bus.duty));
`else
        return ph < (m_prd / 2);
`endif
    endfunction

    function automatic bit m_audible();
`ifdef PIEZO_SEQ_DUTY_EN
        return m_play && (m_prd != 0) && (bus.duty != 4'd0);
`else
        return m_play && (m_prd != 0);
`endif
    endfunction

    task automatic mdl_update();
        bit rpt, any;
        int sel;
        logic [WW-1:0] w;
        if (!rst_n) begin
            m_since = 0; m_fetch = 0; m_play = 0; m_tune = 0; m_addr = 0;
            m_t = 0; m_prd = 0; m_dur = 0; m_last = 0;
        end else begin
            rpt = ((m_since % (RPT + 1)) == RPT);
            any = 0;
            sel = 0;
            for (int i = NT - 1; i >= 0; i--) begin
                if (bus.req[i] && (!bus.rpt_mask[i] || rpt)) begin
                    any = 1;
                    sel = i;
                end
            end
            m_since++;
            if (m_play) begin
                if (m_t >= m_dur) begin
                    m_play = 0;
                    if (any && sel < m_tune) begin
                        m_tune = sel; m_addr = start_of(sel); m_fetch = 1;
                    end else if (!m_last) begin
                        m_addr = (m_addr + 1) % RD; m_fetch = 1;
                    end
                end else begin
                    m_t++;
                end
            end else if (m_fetch) begin
                w = ram_m[m_addr];
                m_last = w[WW-1];
                m_prd = int'(w[WW-2 -: PW]);
                m_dur = int'(w[DW-1:0]);
                m_t = 0; m_fetch = 0; m_play = 1;
            end else if (any) begin
                m_tune = sel; m_addr = start_of(sel); m_fetch = 1;
            end
        end
        if (bus.wr_en) ram_m[bus.wr_addr] = bus.wr_data;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [63:0] act, exp;
        @(negedge clk);
        act = 64'({bus.piezo, bus.piezo_n, bus.busy, bus.tune_id, bus.note_idx});
        exp = 64'({m_audible() && m_tone(), m_audible() && !m_tone(),
                   m_fetch || m_play, TW'(m_tune), AW'(m_addr)});
        chk("model", act, exp);
        mdl_update();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int a, input bit last, input int prd, input int dur);
        bus.wr_en = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = {last, PW'(prd), DW'(dur)};
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic set_start(input int i, input int a);
        bus.tune_start[i*AW +: AW] = AW'(a);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NT-1:0] req;
        logic [NT-1:0] mask;
        logic          busy;
        logic [TW-1:0] tid;
        logic [AW-1:0] idx;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, bad, cnt;
        bit lastb;

        bus.req = '0; bus.rpt_mask = '0; bus.tune_start = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef PIEZO_SEQ_DUTY_EN
        bus.duty = 4'd8;
`endif
        m_since = 0; m_fetch = 0; m_play = 0; m_tune = 0; m_addr = 0;
        m_t = 0; m_prd = 0; m_dur = 0; m_last = 0;

        rst_n = 1'b0;
        steps(2);
        chk("reset_outputs", 64'({bus.piezo, bus.piezo_n, bus.busy, bus.tune_id, bus.note_idx}), 64'd0);
        for (int a = 0; a < RD; a++) wr(a, 1'b1, 0, 0);
        rst_n = 1'b1;

        // priority / mask table, each entry from a fresh reset
        tbl[0] = '{3'b001, 3'b000, 1'b1, 2'd0, 4'd2};
        tbl[1] = '{3'b110, 3'b000, 1'b1, 2'd1, 4'd6};
        tbl[2] = '{3'b100, 3'b000, 1'b1, 2'd2, 4'd12};
        tbl[3] = '{3'b011, 3'b001, 1'b1, 2'd1, 4'd6};
        tbl[4] = '{3'b111, 3'b011, 1'b1, 2'd2, 4'd12};
        tbl[5] = '{3'b010, 3'b010, 1'b0, 2'd0, 4'd0};
        tbl[6] = '{3'b101, 3'b101, 1'b0, 2'd0, 4'd0};
        tbl[7] = '{3'b000, 3'b000, 1'b0, 2'd0, 4'd0};
        set_start(0, 2); set_start(1, 6); set_start(2, 12);
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.req = tbl[i].req;
            bus.rpt_mask = tbl[i].mask;
            step();
            chk($sformatf("tbl%0d", i), 64'({bus.busy, bus.tune_id, bus.note_idx}),
                64'({tbl[i].busy, tbl[i].tid, tbl[i].idx}));
            bus.req = '0;
            bus.rpt_mask = '0;
        end

        // basic tune
        wr(0, 1'b0, 100, 1000);
        wr(1, 1'b1, 50, 500);
        set_start(0, 0);
        do_reset();
        bus.req = 3'b001;
        step();
        chk("basic_busy_n1", 64'(bus.busy), 64'd1);
        bus.req = '0;
        step();
        chk("basic_piezo_n2", 64'(bus.piezo), 64'd1);
        hi = 0;
        for (int i = 0; i < 101; i++) begin
            hi += int'(bus.piezo);
            step();
        end
        chk("basic_high_per_101", 64'(hi), 64'd50);
        steps(899);
        chk("basic_still_note0", 64'({bus.busy, bus.note_idx}), 64'({1'b1, 4'd0}));
        step();
        chk("basic_note_idx1", 64'({bus.busy, bus.note_idx}), 64'({1'b1, 4'd1}));
        steps(501);
        chk("basic_last_play", 64'(bus.busy), 64'd1);
        step();
        chk("basic_idle_silent", 64'({bus.piezo, bus.piezo_n, bus.busy}), 64'd0);

        // preemption only at a note boundary
        wr(5, 1'b0, 10, 40);
        wr(6, 1'b1, 10, 40);
        set_start(1, 5);
        do_reset();
        bus.req = 3'b110;
        step();
        chk("prio_tid1", 64'({bus.tune_id, bus.note_idx}), 64'({2'd1, 4'd5}));
        steps(11);
        bus.req = 3'b111;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tune_id !== 2'd1 || bus.note_idx !== 4'd5) bad++;
        end
        chk("prio_no_midnote_switch", 64'(bad), 64'd0);
        step();
        chk("prio_preempt_fetch", 64'({bus.busy, bus.tune_id, bus.note_idx}), 64'({1'b1, 2'd0, 4'd0}));
        do_reset();

        // address wrap and rest note
        wr(15, 1'b0, 0, 20);
        wr(0, 1'b1, 40, 80);
        set_start(0, 15);
        do_reset();
        bus.req = 3'b001;
        step();
        chk("wrap_fetch15", 64'(bus.note_idx), 64'd15);
        bus.req = '0;
        step();
        cnt = 0;
        for (int i = 0; i < 21; i++) begin
            if (bus.busy && !bus.piezo && !bus.piezo_n) cnt++;
            step();
        end
        chk("rest_silent_cycles", 64'(cnt), 64'd21);
        chk("wrap_to_0", 64'({bus.busy, bus.note_idx}), 64'({1'b1, 4'd0}));

        // reset mid-note
        set_start(0, 0);
        do_reset();
        bus.req = 3'b001;
        steps(2);
        bus.req = '0;
        steps(3);
        chk("rst_pre_playing", 64'({bus.piezo, bus.busy}), 64'({1'b1, 1'b1}));
        rst_n = 1'b0;
        step();
        chk("rst_midnote_silent", 64'({bus.piezo, bus.piezo_n, bus.busy}), 64'd0);
        rst_n = 1'b1;
        steps(5);
        chk("rst_no_replay", 64'(bus.busy), 64'd0);
        bus.req = 3'b001;
        step();
        chk("rst_new_elig", 64'(bus.busy), 64'd1);
        bus.req = '0;

`ifdef PIEZO_SEQ_DUTY_EN
        wr(0, 1'b1, 100, 300);
        do_reset();
        bus.duty = 4'd4;
        bus.req = 3'b001;
        steps(2);
        bus.req = '0;
        hi = 0;
        for (int i = 0; i < 101; i++) begin
            hi += int'(bus.piezo);
            step();
        end
        chk("duty4_high", 64'(hi), 64'd25);
        bus.duty = 4'd0;
        hi = 0;
        for (int i = 0; i < 101; i++) begin
            hi += int'(bus.piezo | bus.piezo_n);
            step();
        end
        chk("duty0_silent", 64'(hi), 64'd0);
        bus.duty = 4'd8;
`endif

        // repeat gating, request held from reset
        wr(3, 1'b1, 5, 10);
        set_start(1, 3);
        rst_n = 1'b0;
        bus.req = 3'b010;
        bus.rpt_mask = 3'b010;
        steps(2);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.busy !== 1'b0) bad++;
        end
        chk("rpt_no_early_busy", 64'(bad), 64'd0);
        step();
        chk("rpt_busy_at_2001", 64'(bus.busy), 64'd1);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.busy) cnt++;
        end
        chk("rpt_one_play_only", 64'(cnt), 64'd11);
        step();
        chk("rpt_second_pulse", 64'(bus.busy), 64'd1);
        bus.req = '0;
        bus.rpt_mask = '0;

        // randomized traffic against the model
        for (int a = 0; a < RD; a++) begin
            lastb = ($urandom_range(2) == 0);
            wr(a, lastb, int'($urandom_range(20)), int'($urandom_range(40)));
        end
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(19) == 0) bus.req = NT'($urandom);
            if ($urandom_range(199) == 0) begin
                bus.rpt_mask = NT'($urandom);
                for (int i = 0; i < NT; i++) set_start(i, int'($urandom_range(15)));
            end
            lastb = ($urandom_range(2) == 0);
            bus.wr_en = ($urandom_range(19) == 0);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = {lastb, PW'($urandom_range(20)), DW'($urandom_range(40))};
            rst_n = ($urandom_range(2999) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
